// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator: combinational decode into a 2-entry
// elastic buffer (head + skid) with registered valid/ready and an illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [2:0]      o_src_imm,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal,
    output logic [CNTW-1:0] o_illegal_cnt
);

    typedef struct packed {
        logic [2:0]      typ;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;

    // Build the 32-bit immediate first, then sign-extend it to XLEN in one place.
    function automatic entry_t decode(input logic [31:0] ins);
        entry_t      e;
        logic [31:0] imm32;
        imm32 = 32'd0;
        e.typ = T_NONE;
        e.ill = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                e.typ = T_NONE;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                e.typ = T_I;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                e.typ = T_S;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                e.typ = T_B;
                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.typ = T_U;
                imm32 = {ins[31:12], 12'd0};
            end
            7'b1101111: begin
                e.typ = T_J;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: begin
                e.typ = T_NONE;
                e.ill = 1'b1;
            end
        endcase
        e.imm = XLEN'($signed(imm32));
        return e;
    endfunction

    logic [1:0]      occ_r, occ_s;
    logic            valid_r, ready_r;
    entry_t          head_r, head_s, skid_r, skid_s, dec_s;
    logic [CNTW-1:0] cnt_r, cnt_s;
    logic            push_s, pop_s;

    assign dec_s  = decode(i_instr);
    assign push_s = i_valid & ready_r;
    assign pop_s  = valid_r & i_ready;

    // Buffer next-state: FIFO order, head drives outputs, skid holds the second entry.
    always_comb begin
        occ_s  = occ_r;
        head_s = head_r;
        skid_s = skid_r;
        if (i_flush) begin
            occ_s = 2'd0;
        end else begin
            case (occ_r)
                2'd0: begin
                    if (push_s) begin
                        head_s = dec_s;
                        occ_s  = 2'd1;
                    end else begin
                        occ_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_s = dec_s;
                    end else if (push_s) begin
                        skid_s = dec_s;
                        occ_s  = 2'd2;
                    end else if (pop_s) begin
                        occ_s = 2'd0;
                    end else begin
                        occ_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_s = skid_r;
                        if (push_s) begin
                            skid_s = dec_s;
                        end else begin
                            occ_s = 2'd1;
                        end
                    end else begin
                        occ_s = 2'd2;
                    end
                end
                default: begin
                    occ_s = 2'd0;
                end
            endcase
        end
    end

    // Illegal counter: counts every accepted illegal word, even one discarded by a flush.
    always_comb begin
        if (push_s && dec_s.ill && (cnt_r != {CNTW{1'b1}})) begin
            cnt_s = cnt_r + CNTW'(1'b1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State registers; valid/ready are derived from next occupancy so both stay registered.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            head_r  <= '0;
            skid_r  <= '0;
            cnt_r   <= '0;
        end else begin
            occ_r   <= occ_s;
            valid_r <= (occ_s != 2'd0);
            ready_r <= (occ_s != 2'd2);
            head_r  <= head_s;
            skid_r  <= skid_s;
            cnt_r   <= cnt_s;
        end
    end

    assign o_valid       = valid_r;
    assign o_ready       = ready_r;
    assign o_src_imm     = head_r.typ;
    assign o_imm         = head_r.imm;
    assign o_illegal     = head_r.ill;
    assign o_illegal_cnt = cnt_r;

endmodule
